// File: rtl/printf_line_buf_if.sv
// Byte-stream handshake bundle between the printf sink, the line buffer and the console.
// The master side feeds bytes and accepts committed output; the slave side is the buffer.
interface printf_line_buf_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last
    );
endinterface

// File: rtl/printf_line_buf.sv
// Line buffer behind the AXI printf sink: bytes become visible downstream only once their
// line is committed by a newline, by the FIFO filling up, or by an idle-time flush.
module printf_line_buf #(
    parameter  int DEPTH        = 64,
    parameter  int FLUSH_CYCLES = 256,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    printf_line_buf_if.slave bus,
    output logic [AW:0]      level,
    output logic             overflow,
    output logic [15:0]      drop_cnt,
    input  logic             clr_stats
);
    localparam int              IW        = $clog2(FLUSH_CYCLES);
    localparam logic [AW:0]     FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]     PTR_ONE   = (AW+1)'(1);
    localparam logic [IW-1:0]   IDLE_ONE  = IW'(1);
    localparam logic [IW-1:0]   IDLE_LAST = IW'(FLUSH_CYCLES - 1);

    logic [8:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   cm_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_prev;
    logic [IW-1:0] idle_cnt;
    logic          full;
    logic          wr_en;
    logic          wr_last;
    logic          partial;
    logic          flush;
    logic          pop;

    // Full is judged on registered pointers, so a same-cycle pop never rescues a write.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == FULL_LVL);
    assign wr_en   = bus.in_valid && !full;
    assign wr_last = (bus.in_data == 8'h0A) || (level == FULL_LVL - PTR_ONE);
    assign wr_prev = wr_ptr - PTR_ONE;
    assign partial = (wr_ptr != cm_ptr);
    assign flush   = !bus.in_valid && partial && (idle_cnt == IDLE_LAST);

    // Only the committed region [rd_ptr, cm_ptr) is ever exposed.
    assign bus.out_valid = (rd_ptr != cm_ptr);
    assign pop           = bus.out_valid && bus.out_ready;
    assign {bus.out_last, bus.out_data} = mem[rd_ptr[AW-1:0]];

    // NOTE: the storage array is deliberately not reset; the pointers alone define live entries.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {wr_last, bus.in_data};
        end else if (flush) begin
            mem[wr_prev[AW-1:0]][8] <= 1'b1;
        end
    end

    // NOTE: all state updates are non-blocking so every branch sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            cm_ptr   <= '0;
            rd_ptr   <= '0;
            idle_cnt <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            if (wr_en && wr_last) begin
                cm_ptr <= wr_ptr + PTR_ONE;
            end else if (flush) begin
                cm_ptr <= wr_ptr;
            end

            // Idle counter only runs while an uncommitted tail is waiting.
            if (bus.in_valid || !partial || flush) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IDLE_ONE;
            end

            if (clr_stats) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else if (bus.in_valid && full) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_printf_line_buf.sv
// Directed bench for printf_line_buf (DEPTH=8, FLUSH_CYCLES=16): newline commit, idle flush,
// forced commit at full, drops and stats clear, stalled output stability, and mid-line reset.
module tb_printf_line_buf;
    localparam int DEPTH        = 8;
    localparam int FLUSH_CYCLES = 16;
    localparam int AW           = $clog2(DEPTH);

    logic        clk;
    logic        rst_n;
    logic        clr_stats;
    logic [AW:0] level;
    logic        overflow;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    printf_line_buf_if bus ();

    printf_line_buf #(
        .DEPTH        (DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_stats (clr_stats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    logic [7:0] exp_bytes [12] = '{8'h61, 8'h62, 8'h0A,
                                   8'h78, 8'h79, 8'h7A, 8'h0A,
                                   8'h31, 8'h32, 8'h33, 8'h34, 8'h0A};
    int         line_len [3]   = '{3, 4, 5};

    initial begin
        int         base;
        int         idx;
        logic       ready;
        logic       stalled;
        logic [7:0] held_d;
        logic       held_l;

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        clr_stats     = 1'b0;
        rst_n         = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_out_valid", 16'(bus.out_valid), 16'h0);
        check("rst_level", 16'(level), 16'h0);
        check("rst_overflow", 16'(overflow), 16'h0);
        check("rst_drop_cnt", drop_cnt, 16'h0);

        // Newline commit with consumer always ready.
        bus.out_ready = 1'b1;
        put(8'h48);
        check("t1_no_leak_a", 16'(bus.out_valid), 16'h0);
        check("t1_level_a", 16'(level), 16'h1);
        put(8'h69);
        check("t1_no_leak_b", 16'(bus.out_valid), 16'h0);
        put(8'h0A);
        check("t1_valid", 16'(bus.out_valid), 16'h1);
        check("t1_level3", 16'(level), 16'h3);
        check("t1_d0", 16'(bus.out_data), 16'h48);
        check("t1_l0", 16'(bus.out_last), 16'h0);
        tick();
        check("t1_d1", 16'(bus.out_data), 16'h69);
        check("t1_l1", 16'(bus.out_last), 16'h0);
        tick();
        check("t1_d2", 16'(bus.out_data), 16'h0A);
        check("t1_l2", 16'(bus.out_last), 16'h1);
        tick();
        check("t1_empty", 16'(bus.out_valid), 16'h0);
        check("t1_level0", 16'(level), 16'h0);

        // Idle flush of a partial line.
        put(8'h61);
        put(8'h62);
        for (int i = 0; i < FLUSH_CYCLES - 1; i++) begin
            tick();
            check("t2_hold", 16'(bus.out_valid), 16'h0);
        end
        check("t2_level", 16'(level), 16'h2);
        tick();
        check("t2_valid", 16'(bus.out_valid), 16'h1);
        check("t2_d0", 16'(bus.out_data), 16'h61);
        check("t2_l0", 16'(bus.out_last), 16'h0);
        tick();
        check("t2_d1", 16'(bus.out_data), 16'h62);
        check("t2_l1", 16'(bus.out_last), 16'h1);
        tick();
        check("t2_empty", 16'(bus.out_valid), 16'h0);

        // Fill to DEPTH without newline, then overflow.
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h61 + i);
            tick();
            if (i == DEPTH - 2) check("t3_not_committed", 16'(bus.out_valid), 16'h0);
        end
        bus.in_valid = 1'b0;
        check("t3_level_full", 16'(level), 16'(DEPTH));
        check("t3_committed", 16'(bus.out_valid), 16'h1);
        put(8'h69);
        check("t3_level_after_drop", 16'(level), 16'(DEPTH));
        check("t3_overflow", 16'(overflow), 16'h1);
        check("t3_drop_cnt", drop_cnt, 16'h1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("t3_clr_overflow", 16'(overflow), 16'h0);
        check("t3_clr_drop_cnt", drop_cnt, 16'h0);
        check("t3_head", 16'(bus.out_data), 16'h61);

        // Pop and write at full in the same cycle: write is dropped.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h7A;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("t4_level", 16'(level), 16'h7);
        check("t4_drop_cnt", drop_cnt, 16'h1);
        check("t4_overflow", 16'(overflow), 16'h1);
        bus.out_ready = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            check("t4_data", 16'(bus.out_data), 16'(8'h61 + i));
            check("t4_last", 16'(bus.out_last), 16'(i == DEPTH - 1));
            tick();
        end
        check("t4_empty", 16'(bus.out_valid), 16'h0);
        check("t4_level0", 16'(level), 16'h0);

        // Three lines drained under random backpressure.
        base = 0;
        for (int ln = 0; ln < 3; ln++) begin
            bus.out_ready = 1'b0;
            for (int k = 0; k < line_len[ln]; k++) put(exp_bytes[base + k]);
            idx = 0;
            for (int cyc = 0; cyc < 200 && idx < line_len[ln]; cyc++) begin
                ready = (cyc % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
                bus.out_ready = ready;
                stalled = 1'b0;
                if (bus.out_valid) begin
                    if (ready) begin
                        check("t5_data", 16'(bus.out_data), 16'(exp_bytes[base + idx]));
                        check("t5_last", 16'(bus.out_last), 16'(exp_bytes[base + idx] == 8'h0A));
                        idx++;
                    end else begin
                        stalled = 1'b1;
                        held_d  = bus.out_data;
                        held_l  = bus.out_last;
                    end
                end
                tick();
                if (stalled) begin
                    check("t5_hold_valid", 16'(bus.out_valid), 16'h1);
                    check("t5_hold_data", 16'(bus.out_data), 16'(held_d));
                    check("t5_hold_last", 16'(bus.out_last), 16'(held_l));
                end
            end
            check("t5_line_done", 16'(idx), 16'(line_len[ln]));
            base += line_len[ln];
        end
        bus.out_ready = 1'b0;
        check("t5_empty", 16'(bus.out_valid), 16'h0);

        // Reset in the middle of a partial line discards it; drop_cnt is still 1 from above.
        check("t6_pre_drop_cnt", drop_cnt, 16'h1);
        put(8'h41);
        put(8'h42);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_out_valid", 16'(bus.out_valid), 16'h0);
        check("t6_level", 16'(level), 16'h0);
        check("t6_drop_cnt", drop_cnt, 16'h0);
        check("t6_overflow", 16'(overflow), 16'h0);
        put(8'h43);
        put(8'h0A);
        check("t6_level2", 16'(level), 16'h2);
        check("t6_valid", 16'(bus.out_valid), 16'h1);
        check("t6_d0", 16'(bus.out_data), 16'h43);
        check("t6_l0", 16'(bus.out_last), 16'h0);
        bus.out_ready = 1'b1;
        tick();
        check("t6_d1", 16'(bus.out_data), 16'h0A);
        check("t6_l1", 16'(bus.out_last), 16'h1);
        tick();
        check("t6_empty", 16'(bus.out_valid), 16'h0);
        check("t6_level0", 16'(level), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
